// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU: op codes, FSM states and flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpLsl = 3'b100,
        OpLsr = 3'b101,
        OpAsr = 3'b110,
        OpMul = 3'b111
    } alu_op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } alu_state_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier returning the low N bits of the unsigned product.
// The load cycle already retires the first partial product, so N-1 steps follow it.
module shift_add_mul #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         last_o,
    output logic [N-1:0] product_o
);
    localparam int unsigned CW = $clog2(N);

    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Accumulator value after the current step; valid as the product on the last step.
    assign product_o = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_o    = (cnt_q == CW'(1));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = b_i[0] ? a_i : '0;
            mcand_d  = a_i << 1;
            mplier_d = b_i >> 1;
            cnt_d    = CW'(N - 1);
        end else if (step_i) begin
            acc_d    = product_o;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// N-bit multi-cycle ALU with start/done handshake and NZCV flags.
// Shifts move one bit per edge; multiply is delegated to shift_add_mul.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);
    alu_state_t    state_q, state_d;
    alu_op_t       op_q, op_d;
    alu_op_t       op_in;
    logic [N-1:0]  sh_q, sh_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  result_q, result_d;
    logic [3:0]    flags_q, flags_d;
    logic          done_q, done_d;

    logic          mul_load, mul_step, mul_last;
    logic [N-1:0]  mul_prod;

    logic          wr_en, c_flag, v_flag;
    logic [N-1:0]  res;
    logic [N:0]    sum;
    logic [N-1:0]  diff;
    logic [SW-1:0] amt;

    assign op_in = alu_op_t'(op);
    assign amt   = b[SW-1:0];
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = a - b;

    // One-position shift; returns {bit shifted out, shifted value}.
    function automatic logic [N:0] shift1(input alu_op_t o, input logic [N-1:0] v);
        case (o)
            OpLsl:   return {v[N-1], v[N-2:0], 1'b0};
            OpLsr:   return {v[0], 1'b0, v[N-1:1]};
            default: return {v[0], v[N-1], v[N-1:1]};
        endcase
    endfunction

    shift_add_mul #(
        .N(N)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (mul_load),
        .step_i   (mul_step),
        .a_i      (a),
        .b_i      (b),
        .last_o   (mul_last),
        .product_o(mul_prod)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        wr_en    = 1'b0;
        res      = '0;
        c_flag   = 1'b0;
        v_flag   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op_in;
                    unique case (op_in)
                        OpAdd: begin
                            {c_flag, res} = sum;
                            v_flag = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
                            wr_en  = 1'b1;
                        end
                        OpSub: begin
                            res    = diff;
                            c_flag = (a >= b);
                            v_flag = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
                            wr_en  = 1'b1;
                        end
                        OpAnd: begin
                            res   = a & b;
                            wr_en = 1'b1;
                        end
                        OpOr: begin
                            res   = a | b;
                            wr_en = 1'b1;
                        end
                        OpLsl, OpLsr, OpAsr: begin
                            if (amt == '0) begin
                                res   = a;
                                wr_en = 1'b1;
                            end else begin
                                // First position is shifted on the accept edge itself.
                                {c_flag, res} = shift1(op_in, a);
                                if (amt == SW'(1)) begin
                                    wr_en = 1'b1;
                                end else begin
                                    sh_d    = res;
                                    cnt_d   = amt - SW'(1);
                                    state_d = EXEC;
                                end
                            end
                        end
                        OpMul: begin
                            mul_load = 1'b1;
                            state_d  = EXEC;
                        end
                    endcase
                end
            end
            EXEC: begin
                if (op_q == OpMul) begin
                    mul_step = 1'b1;
                    if (mul_last) begin
                        res     = mul_prod;
                        wr_en   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    {c_flag, res} = shift1(op_q, sh_q);
                    sh_d  = res;
                    cnt_d = cnt_q - SW'(1);
                    if (cnt_q == SW'(1)) begin
                        wr_en   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
        if (wr_en) begin
            result_d         = res;
            flags_d[FLAG_N]  = res[N-1];
            flags_d[FLAG_Z]  = (res == '0);
            flags_d[FLAG_C]  = c_flag;
            flags_d[FLAG_V]  = v_flag;
            done_d           = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OpAdd;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        busy   = (state_q == EXEC);
        done   = done_q;
        result = result_q;
        flags  = flags_q;
    end

endmodule
